// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types for the instruction-fetch front end         |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package fetch_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] ir;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : RAM read port and execute-stage instruction stream   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
    import fetch_pkg::*;

    logic [WORD_W-1:0] bus_RAM_ADDRESS;
    logic [WORD_W-1:0] bus_RAM_DATA_OUT;
    logic              wire_RW;
    logic              wire_bus_grant;
    logic              wire_redirect;
    logic [WORD_W-1:0] bus_redirect_pc;
    logic              wire_instr_valid;
    logic              wire_instr_ready;
    logic [WORD_W-1:0] bus_instr_IR;
    logic [WORD_W-1:0] bus_instr_PC;
    logic [WORD_W-1:0] bus_fetch_pc;

    modport master (
        output bus_RAM_ADDRESS, wire_RW, wire_instr_valid,
               bus_instr_IR, bus_instr_PC, bus_fetch_pc,
        input  bus_RAM_DATA_OUT, wire_bus_grant, wire_redirect,
               bus_redirect_pc, wire_instr_ready
    );

    modport slave (
        input  bus_RAM_ADDRESS, wire_RW, wire_instr_valid,
               bus_instr_IR, bus_instr_PC, bus_fetch_pc,
        output bus_RAM_DATA_OUT, wire_bus_grant, wire_redirect,
               bus_redirect_pc, wire_instr_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry circular prefetch buffer of {pc, ir}        |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    input  wire logic         push_i,
    input  wire logic         pop_i,
    input  wire logic         flush_i,
    input  wire fetch_entry_t din_i,
    output fetch_entry_t      dout_o,
    output logic [CNT_W-1:0]  count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Caller guarantees no push when full and no pop when empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : RAM instruction prefetcher feeding the execute stage    |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  wire logic    wire_clock,
    input  wire logic    wire_reset,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state_q,     state_d;
    logic [WORD_W-1:0] fetch_pc_q,  fetch_pc_d;
    logic [WORD_W-1:0] issued_pc_q, issued_pc_d;
    logic              inflight_q,  inflight_d;
    logic              discard_q,   discard_d;

    logic [CNT_W-1:0]  count_w;
    logic [CNT_W:0]    occupancy_w;
    logic              issue_w;
    logic              push_w;
    logic              pop_w;
    fetch_entry_t      push_entry_w;
    fetch_entry_t      head_w;

    // Room check counts the outstanding read; a same-cycle pop does not help.
    assign occupancy_w = {1'b0, count_w} + (CNT_W + 1)'(inflight_q);
    assign issue_w     = !bus.wire_redirect
                       && (state_q != S_FLUSH)
                       && bus.wire_bus_grant
                       && (occupancy_w < (CNT_W + 1)'(DEPTH));

    assign push_w       = inflight_q && !discard_q;
    assign pop_w        = bus.wire_instr_valid && bus.wire_instr_ready;
    assign push_entry_w = '{pc: issued_pc_q, ir: bus.bus_RAM_DATA_OUT};

    always_ff @(posedge wire_clock or posedge wire_reset) begin
        if (wire_reset) begin
            state_q     <= S_RUN;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = issue_w;
        discard_d   = 1'b0;

        if (bus.wire_redirect) begin
            state_d    = S_FLUSH;
            fetch_pc_d = bus.bus_redirect_pc;
            // A read outstanding at the redirect must never reach the FIFO.
            discard_d  = inflight_q;
        end else if (state_q == S_FLUSH) begin
            state_d = S_RUN;
        end else begin
            state_d = issue_w ? S_RUN : S_STALL;
        end

        if (issue_w) begin
            fetch_pc_d  = fetch_pc_q + WORD_W'(1);
            issued_pc_d = fetch_pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (wire_clock),
        .rst_i   (wire_reset),
        .push_i  (push_w),
        .pop_i   (pop_w),
        .flush_i (bus.wire_redirect),
        .din_i   (push_entry_w),
        .dout_o  (head_w),
        .count_o (count_w)
    );

    assign bus.bus_RAM_ADDRESS  = fetch_pc_q;
    assign bus.wire_RW          = 1'b0;
    assign bus.wire_instr_valid = (count_w != '0);
    assign bus.bus_instr_IR     = head_w.ir;
    assign bus.bus_instr_PC     = head_w.pc;
    assign bus.bus_fetch_pc     = fetch_pc_q;

endmodule
`default_nettype wire
